// File: rtl/multiplexer_mxn.sv
// -----------------------------------------------------------------------------
// multiplexer_mxn
//   Registered M-input, N-bit multiplexer. Channel k of the packed 'data' bus
//   sits at bits [k*N +: N] and channel 0 occupies the LSBs. On each enabled
//   rising edge the selected channel is loaded into 'o'. A select at or above M
//   loads zero and clears 'o_valid'. When 'enabler' is low the output holds.
//
//   Optional build macro: MUX_SEL_ERR_EN
//     When defined, this adds the registered 'sel_err' flag and an
//     out-of-range select checker (multiplexer_mxn_chk).
// -----------------------------------------------------------------------------

`ifdef MUX_SEL_ERR_EN
// Simulation-only checker that flags an out-of-range select on an enabled edge.
module multiplexer_mxn_chk #(
    parameter int M  = 2,
    parameter int SW = 1
) (
    input logic          clk,
    input logic          rst_n,
    input logic          enabler,
    input logic [SW-1:0] select
);

    // Widen by one bit so that M itself is representable when M = 2**SW.
    localparam logic [SW:0] M_W = (SW+1)'(M);

    // Report any enabled capture that uses an illegal channel index.
    always @(posedge clk) begin
        if (rst_n && enabler) begin
            assert ({1'b0, select} < M_W);
        end
    end

endmodule
`endif

module multiplexer_mxn #(
    parameter  int M  = 2,
    parameter  int N  = 4,
    localparam int SW = (M > 2) ? $clog2(M) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [SW-1:0]  select,
    input  logic [M*N-1:0] data,
    input  logic           enabler,
    output logic [N-1:0]   o,
    output logic           o_valid
`ifdef MUX_SEL_ERR_EN
    ,
    output logic           sel_err
`endif
);

    logic [N-1:0] sel_data_s;
    logic         sel_legal_s;
    logic [N-1:0] o_r;
    logic         o_valid_r;

    // Decode the select against every legal channel index. An out-of-range
    // value or an unknown (X/Z) value matches no channel, so it falls through
    // to the zero default and is reported as illegal.
    always_comb begin
        sel_data_s  = {N{1'b0}};
        sel_legal_s = 1'b0;
        for (int k = 0; k < M; k++) begin
            if (select == SW'(k)) begin
                sel_data_s  = data[k*N +: N];
                sel_legal_s = 1'b1;
            end else begin
                sel_data_s  = sel_data_s;
                sel_legal_s = sel_legal_s;
            end
        end
    end

    // Output register: reset clears the register, an enabled edge captures
    // the decoded channel, and a disabled edge holds the current value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_r       <= {N{1'b0}};
            o_valid_r <= 1'b0;
        end else if (enabler) begin
            o_r       <= sel_data_s;
            o_valid_r <= sel_legal_s;
        end else begin
            o_r       <= o_r;
            o_valid_r <= o_valid_r;
        end
    end

    assign o       = o_r;
    assign o_valid = o_valid_r;

`ifdef MUX_SEL_ERR_EN
    logic sel_err_r;

    // Sticky select error flag: set by an illegal enabled capture and
    // cleared by a legal one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (enabler) begin
            sel_err_r <= ~sel_legal_s;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    assign sel_err = sel_err_r;

    multiplexer_mxn_chk #(
        .M  (M),
        .SW (SW)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .enabler (enabler),
        .select  (select)
    );
`endif

endmodule

// File: tb/tb_multiplexer_mxn.sv
// -----------------------------------------------------------------------------
// tb_multiplexer_mxn
//   Self-checking bench for multiplexer_mxn. It uses three configurations
//   (M=8/N=5, M=2/N=4 and M=5/N=5). Expected outputs come from a behavioural
//   model, are pushed to per-instance queues at each edge, and are popped and
//   compared one time step after that edge.
// -----------------------------------------------------------------------------
module tb_multiplexer_mxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [2:0]  sel8;
    logic [39:0] data8;
    logic        en8;
    logic [4:0]  o8;
    logic        v8;

    logic        sel2;
    logic [7:0]  data2;
    logic        en2;
    logic [3:0]  o2;
    logic        v2;

    logic [2:0]  sel5;
    logic [24:0] data5;
    logic        en5;
    logic [4:0]  o5;
    logic        v5;

`ifdef MUX_SEL_ERR_EN
    logic        err8;
    logic        err2;
    logic        err5;
    logic        m5_err;
    logic        exp_err_q5[$];
    logic        e_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] o;
        logic       v;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    exp_t q5[$];
    exp_t e;

    logic [4:0] m8_o, m2_o, m5_o;
    logic       m8_v, m2_v, m5_v;

    multiplexer_mxn #(.M(8), .N(5)) u8 (
        .clk(clk), .rst_n(rst_n), .select(sel8), .data(data8),
        .enabler(en8), .o(o8), .o_valid(v8)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(err8)
`endif
    );

    multiplexer_mxn #(.M(2), .N(4)) u2 (
        .clk(clk), .rst_n(rst_n), .select(sel2), .data(data2),
        .enabler(en2), .o(o2), .o_valid(v2)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(err2)
`endif
    );

    multiplexer_mxn #(.M(5), .N(5)) u5 (
        .clk(clk), .rst_n(rst_n), .select(sel5), .data(data5),
        .enabler(en5), .o(o5), .o_valid(v5)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(err5)
`endif
    );

    // Advance the behavioural models by one rising edge using the inputs
    // currently applied, queue the expected results, then wait until just
    // after that edge.
    task automatic advance();
        if (!rst_n) begin
            m8_o = 5'd0; m8_v = 1'b0;
            m2_o = 5'd0; m2_v = 1'b0;
            m5_o = 5'd0; m5_v = 1'b0;
`ifdef MUX_SEL_ERR_EN
            m5_err = 1'b0;
`endif
        end else begin
            if (en8) begin
                m8_o = 5'(int'(sel8) + 1);
                m8_v = 1'b1;
            end
            if (en2) begin
                m2_o = (sel2 == 1'b0) ? 5'b01010 : 5'b01111;
                m2_v = 1'b1;
            end
            if (en5) begin
                if (int'(sel5) < 5) begin
                    m5_o = 5'(int'(sel5) + 1);
                    m5_v = 1'b1;
`ifdef MUX_SEL_ERR_EN
                    m5_err = 1'b0;
`endif
                end else begin
                    m5_o = 5'd0;
                    m5_v = 1'b0;
`ifdef MUX_SEL_ERR_EN
                    m5_err = 1'b1;
`endif
                end
            end
        end
        q8.push_back('{o: m8_o, v: m8_v});
        q2.push_back('{o: m2_o, v: m2_v});
        q5.push_back('{o: m5_o, v: m5_v});
`ifdef MUX_SEL_ERR_EN
        exp_err_q5.push_back(m5_err);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en8 = 1'b1; en2 = 1'b1; en5 = 1'b1;
        sel8 = 3'd3; sel2 = 1'b1; sel5 = 3'd2;
        #2;
        checks++;
        if ({o8, v8} !== 6'd0) begin
            errors++;
            $display("FAIL reset_u8: got o=%b v=%b, want o=00000 v=0", o8, v8);
        end
        checks++;
        if ({o2, v2} !== 5'd0) begin
            errors++;
            $display("FAIL reset_u2: got o=%b v=%b, want o=0000 v=0", o2, v2);
        end
        checks++;
        if ({o5, v5} !== 6'd0) begin
            errors++;
            $display("FAIL reset_u5: got o=%b v=%b, want o=00000 v=0", o5, v5);
        end
        // Holding reset low across an enabled edge must keep the outputs cleared.
        @(negedge clk);
        advance();
        e = q8.pop_front();
        checks++;
        if ({o8, v8} !== {e.o, e.v}) begin
            errors++;
            $display("FAIL reset_wins: got o=%b v=%b, want o=%b v=%b", o8, v8, e.o, e.v);
        end
        void'(q2.pop_front());
        void'(q5.pop_front());
`ifdef MUX_SEL_ERR_EN
        void'(exp_err_q5.pop_front());
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep8();
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            sel8 = 3'(s);
            en8  = 1'b1;
            advance();
            e = q8.pop_front();
            checks++;
            if ({o8, v8} !== {e.o, e.v}) begin
                errors++;
                $display("FAIL sweep8_sel%0d: got o=%b v=%b, want o=%b v=%b", s, o8, v8, e.o, e.v);
            end
            void'(q2.pop_front());
            void'(q5.pop_front());
`ifdef MUX_SEL_ERR_EN
            void'(exp_err_q5.pop_front());
`endif
        end
    endtask

    task automatic test_m2();
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            sel2 = s[0];
            en2  = 1'b1;
            advance();
            e = q2.pop_front();
            checks++;
            if ({o2, v2} !== {e.o[3:0], e.v}) begin
                errors++;
                $display("FAIL m2_sel%0d: got o=%b v=%b, want o=%b v=%b", s, o2, v2, e.o[3:0], e.v);
            end
            void'(q8.pop_front());
            void'(q5.pop_front());
`ifdef MUX_SEL_ERR_EN
            void'(exp_err_q5.pop_front());
`endif
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                sel8 = 3'd2; en8 = 1'b1;
            end else if (c < 4) begin
                sel8 = 3'd7; en8 = 1'b0;
            end else begin
                sel8 = 3'd7; en8 = 1'b1;
            end
            advance();
            e = q8.pop_front();
            checks++;
            if ({o8, v8} !== {e.o, e.v}) begin
                errors++;
                $display("FAIL hold_c%0d: got o=%b v=%b, want o=%b v=%b", c, o8, v8, e.o, e.v);
            end
            void'(q2.pop_front());
            void'(q5.pop_front());
`ifdef MUX_SEL_ERR_EN
            void'(exp_err_q5.pop_front());
`endif
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sel8 = 3'd4; en8 = 1'b1;
        advance();
        e = q8.pop_front();
        checks++;
        if ({o8, v8} !== {e.o, e.v}) begin
            errors++;
            $display("FAIL async_pre: got o=%b v=%b, want o=%b v=%b", o8, v8, e.o, e.v);
        end
        void'(q2.pop_front());
        void'(q5.pop_front());
`ifdef MUX_SEL_ERR_EN
        void'(exp_err_q5.pop_front());
`endif
        // Drop reset mid-cycle. The outputs must clear before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o8, v8} !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: got o=%b v=%b, want o=00000 v=0", o8, v8);
        end
        m8_o = 5'd0; m8_v = 1'b0;
        m2_o = 5'd0; m2_v = 1'b0;
        m5_o = 5'd0; m5_v = 1'b0;
`ifdef MUX_SEL_ERR_EN
        m5_err = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_out_of_range();
        logic [2:0] seq[5];
        seq[0] = 3'd2; seq[1] = 3'd6; seq[2] = 3'd1; seq[3] = 3'd5; seq[4] = 3'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sel5 = seq[i];
            en5  = 1'b1;
            advance();
            e = q5.pop_front();
            checks++;
            if ({o5, v5} !== {e.o, e.v}) begin
                errors++;
                $display("FAIL oor_sel%0d: got o=%b v=%b, want o=%b v=%b", seq[i], o5, v5, e.o, e.v);
            end
`ifdef MUX_SEL_ERR_EN
            e_err = exp_err_q5.pop_front();
            checks++;
            if (err5 !== e_err) begin
                errors++;
                $display("FAIL sel_err_sel%0d: got %b, want %b", seq[i], err5, e_err);
            end
`endif
            void'(q8.pop_front());
            void'(q2.pop_front());
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        sel8 = 3'd2; en8 = 1'b1;
        advance();
        void'(q8.pop_front());
        void'(q2.pop_front());
        void'(q5.pop_front());
`ifdef MUX_SEL_ERR_EN
        void'(exp_err_q5.pop_front());
`endif
        @(negedge clk);
        sel8 = 3'd5;
        #1;
        sel8 = 3'd0;
        #1;
        checks++;
        if (o8 !== 5'b00011) begin
            errors++;
            $display("FAIL glitch_between_edges: got o=%b, want o=00011", o8);
        end
        sel8 = 3'd6;
        #1;
        advance();
        e = q8.pop_front();
        checks++;
        if ({o8, v8} !== {e.o, e.v}) begin
            errors++;
            $display("FAIL glitch_edge: got o=%b v=%b, want o=%b v=%b", o8, v8, e.o, e.v);
        end
        void'(q2.pop_front());
        void'(q5.pop_front());
`ifdef MUX_SEL_ERR_EN
        void'(exp_err_q5.pop_front());
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            sel8 = 3'($urandom_range(0, 7));
            en8  = 1'($urandom_range(0, 1));
            sel2 = 1'($urandom_range(0, 1));
            en2  = 1'($urandom_range(0, 1));
            sel5 = 3'($urandom_range(0, 7));
            en5  = 1'($urandom_range(0, 1));
            advance();
            e = q8.pop_front();
            checks++;
            if ({o8, v8} !== {e.o, e.v}) begin
                errors++;
                $display("FAIL b2b_u8_%0d: got o=%b v=%b, want o=%b v=%b", i, o8, v8, e.o, e.v);
            end
            e = q2.pop_front();
            checks++;
            if ({o2, v2} !== {e.o[3:0], e.v}) begin
                errors++;
                $display("FAIL b2b_u2_%0d: got o=%b v=%b, want o=%b v=%b", i, o2, v2, e.o[3:0], e.v);
            end
            e = q5.pop_front();
            checks++;
            if ({o5, v5} !== {e.o, e.v}) begin
                errors++;
                $display("FAIL b2b_u5_%0d: got o=%b v=%b, want o=%b v=%b", i, o5, v5, e.o, e.v);
            end
`ifdef MUX_SEL_ERR_EN
            e_err = exp_err_q5.pop_front();
            checks++;
            if (err5 !== e_err) begin
                errors++;
                $display("FAIL b2b_err_%0d: got %b, want %b", i, err5, e_err);
            end
`endif
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) data8[k*5 +: 5] = 5'(k + 1);
        data2 = {4'b1111, 4'b1010};
        for (int k = 0; k < 5; k++) data5[k*5 +: 5] = 5'(k + 1);
        m8_o = 5'd0; m8_v = 1'b0;
        m2_o = 5'd0; m2_v = 1'b0;
        m5_o = 5'd0; m5_v = 1'b0;
`ifdef MUX_SEL_ERR_EN
        m5_err = 1'b0;
`endif
        test_reset();
        test_sweep8();
        test_m2();
        test_hold();
        test_async_reset();
        test_out_of_range();
        test_glitch();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplexer_mxn.md
Name:
multiplexer_mxn

Overview:
- Parameterised M-input, N-bit-wide registered multiplexer. Selects one of M packed channels by index and presents it on a registered output.
- Generic datapath building block, used for the register-file read ports, ALU operand select and write-back select in the CPU pipeline.
- Single clock domain with an enable so the selection can be frozen.

Parameters:
- M, default 2, number of input channels (>= 2).
- N, default 4, width of each channel in bits (>= 1).
- SW, default max(1, $clog2(M)), select width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- select  input  SW  channel index, unsigned.
- data  input  M*N  packed channels. Channel k occupies bits [k*N+N-1 : k*N]; channel 0 is at the LSBs.
- enabler  input  1  when 1, the output register loads the selected channel; when 0, the output holds its value.
- o  output  N  registered selected channel.
- o_valid  output  1  high while o holds a legally selected channel.

Behaviour:
- Reset:
  - Asserting rst_n low immediately forces o = 0 and o_valid = 0, independent of clk.
  - Outputs stay there while rst_n is low.
  - Deassertion is synchronised by the user. The first capture happens on the first rising clk edge with rst_n high.
- Capture:
  - On each rising clk edge with enabler = 1, o <= data[select*N +: N].
  - Latency is exactly 1 cycle from select/data to o.
  - There is no combinational path from the inputs to o.
- Hold: on a rising edge with enabler = 0, o and o_valid keep their previous values.
- Legal select (select < M): o_valid <= 1 on an enabled edge.
- Out-of-range select (select >= M, possible only when M is not a power of 2):
  - On an enabled edge, o <= 0 and o_valid <= 0.
  - X must never propagate.
- Select or data changing between edges has no effect; only the values at the edge are sampled.
- Simultaneous reset and enabled edge: reset wins.
- X/Z on select: do not care for synthesis. Simulation must resolve to the out-of-range behaviour via a default branch.
- Implementation is free (case/generate/index), but must be fully parameterised with no hard-coded M or N.

Optional Feature:
- Macro MUX_SEL_ERR_EN.
- When defined:
  - Adds output sel_err (1 bit, registered, reset 0).
  - sel_err is set on an enabled edge with select >= M, and cleared on an enabled edge with a legal select.
  - An immediate assertion flags out-of-range select in simulation.
- When undefined: the port and assertion do not exist; all other behaviour is identical.

Test Plan:
- M=8, N=5, enabler=1, channel k (index 0..7) = k+1 (5'b00001..5'b01000). Sweep select 0..7 with one clock each -> one cycle after each edge, o = select+1 (select=3'b111 -> 5'b01000) and o_valid=1.
- M=2, N=4, ch0=4'b1010, ch1=4'b1111. select=0 then 1 -> o=4'b1010, then 4'b1111, each one cycle late.
- Hold: o=5'b00011 at select=2, then enabler=0, select=7 for 3 cycles -> o stays 5'b00011; re-enable -> 5'b01000 next cycle.
- Async reset: pulse rst_n low mid-cycle while o=5'b00101 -> o=0 and o_valid=0 immediately, before any clk edge.
- M=5, N=5, select=3'b110, enabler=1 -> o=0 and o_valid=0. With MUX_SEL_ERR_EN, sel_err=1, then cleared by select=1.
- Glitch: toggle select between clk edges -> o changes only at the rising edge.
